one_over_one_plus_x: RTL and testbench

//  Computes y = 1/(1+x) for x in [0,1), Q0.31 in, Q0.31 out. Second half of the logistic path:

---
 rtl/one_over_one_plus_x_if.sv | 28 ++
 rtl/one_over_one_plus_x.sv | 140 ++++++++++++++
 tb/tb_one_over_one_plus_x.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/one_over_one_plus_x_if.sv
// Valid/ready stream bundle for the 1/(1+x) block: operand x in, result y out.
// master = the surrounding logic that feeds x and consumes y; slave = the block itself.
interface one_over_one_plus_x_if;
    logic [31:0] x;
    logic        input_valid;
    logic        input_ready;
    logic [31:0] y;
    logic        output_valid;
    logic        output_ready;

    modport master (
        output x,
        output input_valid,
        input  input_ready,
        input  y,
        input  output_valid,
        output output_ready
    );

    modport slave (
        input  x,
        input  input_valid,
        output input_ready,
        output y,
        output output_valid,
        input  output_ready
    );
endinterface

// File: rtl/one_over_one_plus_x.sv
// y = 1/(1+x) for Q0.31 x in [0,1), bit-exact to gemmlowp's Newton-Raphson reciprocal,
// computed iteratively with a single shared 32x32 signed multiplier.
module one_over_one_plus_x #(
    parameter int NR_ITERS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    one_over_one_plus_x_if.slave  bus
);

    localparam logic signed [31:0] C48_17  = 32'sd1515870810;
    localparam logic signed [31:0] CN32_17 = -32'sd1010580540;
    localparam logic signed [31:0] ONE_Q2  = 32'sd536870912;
    localparam logic signed [31:0] INT_MAX = 32'sh7FFFFFFF;
    localparam logic signed [31:0] INT_MIN = 32'sh80000000;
    localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
    localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;
    localparam logic signed [63:0] TRUNC_BIAS = 64'sd2147483647;

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_NR_A, S_NR_B, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         iter_q, iter_d;
    logic signed [31:0] hd_q, hd_d;
    logic signed [31:0] est_q, est_d;
    logic signed [31:0] t_q, t_d;
    logic signed [31:0] y_q, y_d;
    logic signed [31:0] mul_a, mul_b, mul_r, est_new;
    logic signed [63:0] prod;
    logic               accept, last_iter;

    // Saturating rounding doubling high multiply; p is the full product a*b.
    // Division by 2^31 truncates toward zero, hence the bias on negative sums.
    function automatic logic signed [31:0] srdhm(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input logic signed [63:0] p);
        logic signed [63:0] s;
        if (a == INT_MIN && b == INT_MIN) return INT_MAX;
        s = (p >= 0) ? p + NUDGE_POS : p + NUDGE_NEG;
        if (s < 0) s = s + TRUNC_BIAS;
        return 32'(s >>> 31);
    endfunction

    function automatic logic signed [31:0] sat_shl2(input logic signed [31:0] v);
        if (v > 32'sh1FFFFFFF) return INT_MAX;
        if (v < -32'sh20000000) return INT_MIN;
        return v <<< 2;
    endfunction

    function automatic logic signed [31:0] sat_shl1(input logic signed [31:0] v);
        if (v > 32'sh3FFFFFFF) return INT_MAX;
        if (v < -32'sh40000000) return INT_MIN;
        return v <<< 1;
    endfunction

    assign accept    = bus.input_valid && bus.input_ready;
    assign last_iter = (iter_q == 3'(NR_ITERS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SEED;
            S_SEED:  state_d = S_NR_A;
            S_NR_A:  state_d = S_NR_B;
            S_NR_B:  state_d = last_iter ? S_OUT : S_NR_A;
            S_OUT:   if (bus.output_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // input_ready is gated by rst so it stays low for the whole reset assertion.
    always_comb begin
        bus.input_ready  = rst && (state_q == S_IDLE);
        bus.output_valid = (state_q == S_OUT);
    end

    assign bus.y = y_q;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_SEED: begin mul_a = hd_q;  mul_b = CN32_17; end
            S_NR_A: begin mul_a = hd_q;  mul_b = est_q;   end
            S_NR_B: begin mul_a = est_q; mul_b = t_q;     end
            default: ;
        endcase
        prod    = 64'(mul_a) * 64'(mul_b);
        mul_r   = srdhm(mul_a, mul_b, prod);
        est_new = est_q + sat_shl2(mul_r);
    end

    always_comb begin
        hd_d   = hd_q;
        est_d  = est_q;
        t_d    = t_q;
        y_d    = y_q;
        iter_d = iter_q;
        case (state_q)
            S_IDLE: begin
                // (x + 1)/2 with x[31] cleared: half denominator in [0.5, 1)
                if (accept)
                    hd_d = $signed(32'((33'(bus.x & 32'h7FFFFFFF) + 33'h080000000) >> 1));
            end
            S_SEED: begin
                est_d  = C48_17 + mul_r;
                iter_d = '0;
            end
            S_NR_A: t_d = ONE_Q2 - mul_r;
            S_NR_B: begin
                est_d  = est_new;
                iter_d = iter_q + 3'd1;
                if (last_iter) y_d = sat_shl1(est_new);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hd_q   <= '0;
            est_q  <= '0;
            t_q    <= '0;
            y_q    <= '0;
            iter_q <= '0;
        end else begin
            hd_q   <= hd_d;
            est_q  <= est_d;
            t_q    <= t_d;
            y_q    <= y_d;
            iter_q <= iter_d;
        end
    end

endmodule

// File: tb/tb_one_over_one_plus_x.sv
// Directed and randomised bench for one_over_one_plus_x against a gemmlowp reference model.
module tb_one_over_one_plus_x;

    localparam int     NR_ITERS = 3;
    localparam int     LAT      = 2 + 2 * NR_ITERS;
    localparam longint TWO31    = 64'sd2147483648;
    localparam longint TWO30    = 64'sd1073741824;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    one_over_one_plus_x_if bus();

    one_over_one_plus_x #(.NR_ITERS(NR_ITERS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic longint m_sat32(input longint v);
        if (v > TWO31 - 1) return TWO31 - 1;
        if (v < -TWO31) return -TWO31;
        return v;
    endfunction

    function automatic longint m_wrap32(input longint v);
        int w;
        w = int'(v);
        return longint'(w);
    endfunction

    function automatic longint m_srdhm(input longint a, input longint b);
        longint p;
        if (a == -TWO31 && b == -TWO31) return TWO31 - 1;
        p = a * b;
        if (p >= 0) return (p + TWO30) / TWO31;
        return (p + 1 - TWO30) / TWO31;
    endfunction

    function automatic logic [31:0] model_y(input logic [31:0] xin);
        longint hd, e, t;
        hd = (longint'({1'b0, xin[30:0]}) + TWO31) / 2;
        e  = m_wrap32(64'sd1515870810 + m_srdhm(hd, -64'sd1010580540));
        for (int i = 0; i < NR_ITERS; i++) begin
            t = m_wrap32(64'sd536870912 - m_srdhm(hd, e));
            e = m_wrap32(e + m_sat32(4 * m_srdhm(e, t)));
        end
        return 32'(m_sat32(2 * e));
    endfunction

    function automatic logic [31:0] near(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = (a > b) ? a - b : b - a;
        return 32'(d <= 32'd4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] xv, output int lat);
        int w;
        w = 0;
        while (!bus.input_ready && w < 20) begin
            tick();
            w++;
        end
        check_val("in_ready_wait", 32'(bus.input_ready), 32'd1);
        bus.x           = xv;
        bus.input_valid = 1'b1;
        tick();
        bus.input_valid = 1'b0;
        bus.x           = $urandom;
        lat = 1;
        while (!bus.output_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic recv(output logic [31:0] yv);
        yv = bus.y;
        bus.output_ready = 1'b1;
        tick();
        bus.output_ready = 1'b0;
    endtask

    task automatic run_directed(input string tag, input logic [31:0] xv, output logic [31:0] yv);
        int lat;
        send(xv, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(LAT));
        recv(yv);
        check_val({tag, "_y"}, yv, model_y(xv));
        check_val({tag, "_idle"}, 32'(bus.input_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] yv;
        logic [31:0] xtab [5];
        int lat, seen, w;
        logic r;

        rst = 1'b0;
        bus.x = '0;
        bus.input_valid = 1'b0;
        bus.output_ready = 1'b0;
        #2;
        check_val("rst_y", bus.y, 32'h0);
        check_val("rst_ovalid", 32'(bus.output_valid), 32'd0);
        check_val("rst_iready", 32'(bus.input_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("rel_iready", 32'(bus.input_ready), 32'd1);

        // x = 0: estimate reaches exactly 2.0, so the doubled result saturates
        run_directed("x_zero", 32'h00000000, yv);
        check_val("x_zero_sat", yv, 32'h7FFFFFFF);

        run_directed("x_half", 32'h40000000, yv);
        check_val("x_half_near", near(yv, 32'h55555555), 32'd1);

        run_directed("x_max", 32'h7FFFFFFF, yv);
        check_val("x_max_near", near(yv, 32'h40000000), 32'd1);

        run_directed("x_msb", 32'hC0000000, yv);
        check_val("x_msb_as_half", yv, model_y(32'h40000000));

        // downstream stall: result held, block refuses new operands
        send(32'h20000000, lat);
        check_val("stall_lat", 32'(lat), 32'(LAT));
        bus.input_valid = 1'b1;
        bus.x = 32'h7FFFFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("stall_y", bus.y, model_y(32'h20000000));
            check_val("stall_ovalid", 32'(bus.output_valid), 32'd1);
            check_val("stall_iready", 32'(bus.input_ready), 32'd0);
        end
        bus.input_valid = 1'b0;
        recv(yv);
        check_val("stall_y_final", yv, model_y(32'h20000000));
        check_val("stall_ov_drop", 32'(bus.output_valid), 32'd0);
        run_directed("after_stall", 32'h10000000, yv);

        // reset while the block is in NR_B
        w = 0;
        while (!bus.input_ready && w < 20) begin tick(); w++; end
        bus.x = 32'h30000000;
        bus.input_valid = 1'b1;
        tick();
        bus.input_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_y", bus.y, 32'h0);
        check_val("mid_rst_ovalid", 32'(bus.output_valid), 32'd0);
        check_val("mid_rst_iready", 32'(bus.input_ready), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_val("mid_rel_iready", 32'(bus.input_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.output_valid) seen++;
        end
        check_val("no_stale_ovalid", 32'(seen), 32'd0);
        run_directed("after_rst", 32'h30000000, yv);

        // randomised operands and downstream backpressure
        xtab[0] = 32'h00000001;
        xtab[1] = 32'h80000000;
        xtab[2] = 32'hFFFFFFFF;
        xtab[3] = 32'h7FFFFFFE;
        xtab[4] = 32'h00010000;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] xv;
            xv = (n < 5) ? xtab[n] : $urandom;
            repeat ($urandom_range(0, 2)) tick();
            send(xv, lat);
            check_val("rnd_lat", 32'(lat), 32'(LAT));
            for (int k = 0; k < 40; k++) begin
                r = (k == 39) ? 1'b1 : 1'($urandom_range(0, 1));
                check_val("rnd_y", bus.y, model_y(xv));
                bus.output_ready = r;
                tick();
                bus.output_ready = 1'b0;
                if (r) break;
            end
            check_val("rnd_done", 32'(bus.output_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
